// File: rtl/bmult_share_pkg.sv
// bmult_share_pkg
// Shared definitions for the shared Booth-multiplier scheduler.
//   W_DEF / NUM_REQ_DEF / LAT_DEF / FIFO_DEPTH_DEF : default configuration
//   ID_W    : requester index width for the default NUM_REQ
//   rsp_t   : one response FIFO entry {requester id, 2W-bit product}
package bmult_share_pkg;

  localparam int W_DEF          = 10;
  localparam int NUM_REQ_DEF    = 4;
  localparam int LAT_DEF        = 1;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int ID_W = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [2*W_DEF-1:0]   product;
  } rsp_t;

endpackage

// File: rtl/bmult_share_fifo.sv
// bmult_share_fifo
// Synchronous show-ahead FIFO. The head entry is presented on rd_data
// whenever the FIFO is not empty; a write into an empty FIFO becomes
// visible on the following cycle (no fall-through path).
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_data : push one entry (ignored when full)
//   rd_en         : pop the head entry (ignored when empty)
//   rd_data       : head entry, zero while empty
//   count         : number of stored entries
//   full, empty   : status flags
module bmult_share_fifo
  import bmult_share_pkg::*;
#(
  parameter type entry_t = rsp_t,
  parameter int  DEPTH   = FIFO_DEPTH_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  entry_t       wr_data,
  input  logic         rd_en,
  output entry_t       rd_data,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  logic do_write;
  logic do_read;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;

  // Head is forced to zero while empty so the outputs are clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bmult_share_sched.sv
// bmult_share_sched
// Round-robin scheduler sharing one pipelined Booth-multiplier datapath
// between NUM_REQ requesters. Accepted operand pairs are issued one per
// cycle; requester ids follow the datapath through a LAT-deep tag pipeline
// and completed products are queued in a response FIFO.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake
//   req_a, req_b         : per-requester signed operands
//   mult_vld/mult_a/b    : registered issue to the datapath
//   mult_p               : datapath product (bit 2W is ignored)
//   rsp_valid/rsp_ready  : response handshake (FIFO head)
//   rsp_id, rsp_p        : requester index and product of the head
module bmult_share_sched
  import bmult_share_pkg::*;
#(
  parameter int  NUM_REQ    = NUM_REQ_DEF,
  parameter int  W          = W_DEF,
  parameter int  LAT        = LAT_DEF,
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0][W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][W-1:0]   req_b,
  output logic                        mult_vld,
  output logic [W-1:0]                mult_a,
  output logic [W-1:0]                mult_b,
  input  logic [2*W:0]                mult_p,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDX_W-1:0]            rsp_id,
  output logic [2*W-1:0]              rsp_p
);

  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  // Same layout as rsp_t, sized for this instance's parameters.
  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [2*W-1:0]   product;
  } entry_t;

  logic [OCC_W-1:0]             occ;
  logic [IDX_W-1:0]             rr_ptr;
  logic [IDX_W-1:0]             iss_id;
  logic [LAT-1:0]               tag_vld;
  logic [LAT-1:0][IDX_W-1:0]    tag_id;

  logic                         grant_ok;
  logic                         found;
  logic [IDX_W-1:0]             winner;
  logic [IDX_W:0]               cand_sum;
  logic [IDX_W-1:0]             cand;
  logic                         accept;
  logic                         pop;

  entry_t                       fifo_wr_data;
  entry_t                       fifo_head;
  logic                         fifo_empty;
  logic [FIFO_AW:0]             unused_fifo_count;
  logic                         unused_fifo_full;
  logic                         unused_p_msb;

  // Occupancy covers everything accepted but not yet popped, so granting
  // only while occ < FIFO_DEPTH means every in-flight product has a slot.
  // Using the registered occ keeps a same-cycle pop out of the grant path.
  always_comb begin
    grant_ok  = (occ < OCC_W'(FIFO_DEPTH));
    found     = 1'b0;
    winner    = '0;
    cand_sum  = '0;
    cand      = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (!rst && grant_ok && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign accept = |req_ready;
  assign pop    = rsp_valid && rsp_ready;

  // Issue register, round-robin pointer and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= '0;
      rr_ptr   <= '0;
      mult_vld <= 1'b0;
      mult_a   <= '0;
      mult_b   <= '0;
      iss_id   <= '0;
    end else begin
      mult_vld <= accept;
      if (accept) begin
        mult_a <= req_a[winner];
        mult_b <= req_b[winner];
        iss_id <= winner;
        rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Tag pipeline: the id issued with mult_vld reaches the last stage in the
  // same cycle the datapath presents that product. Written as a vector
  // shift so the same code covers LAT = 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= (tag_vld << 1) | LAT'(mult_vld);
      tag_id  <= (tag_id << IDX_W) | (LAT*IDX_W)'(iss_id);
    end
  end

  assign fifo_wr_data.id      = tag_id[LAT-1];
  assign fifo_wr_data.product = mult_p[2*W-1:0];
  assign unused_p_msb         = mult_p[2*W];

  bmult_share_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_vld[LAT-1]),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (unused_fifo_count),
    .full    (unused_fifo_full),
    .empty   (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_head.id;
  assign rsp_p     = fifo_head.product;

endmodule

// File: tb/tb_bmult_share_sched.sv
// tb_bmult_share_sched
// Bench for bmult_share_sched with a one-stage behavioural datapath.
// A reference process predicts every grant and pushes the expected response
// into a scoreboard queue; a separate monitor checks rsp_* against the head.
module tb_bmult_share_sched;
  import bmult_share_pkg::*;

  localparam int NREQ      = 4;
  localparam int WD        = 10;
  localparam int LATY      = 1;
  localparam int DEPTH     = 4;
  localparam int IW        = $clog2(NREQ);
  localparam int RSP_DELAY = 2 + LATY;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][WD-1:0]  req_a;
  logic [NREQ-1:0][WD-1:0]  req_b;
  logic                     mult_vld;
  logic [WD-1:0]            mult_a;
  logic [WD-1:0]            mult_b;
  logic [2*WD:0]            mult_p;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IW-1:0]            rsp_id;
  logic [2*WD-1:0]          rsp_p;

  typedef struct {
    int              id;
    logic [2*WD-1:0] p;
    int              avail;
  } exp_t;

  exp_t            scoreboard[$];
  int              cycle     = 0;
  int              n_cmp     = 0;
  int              n_fail    = 0;
  int              acc_count = 0;
  int              m_ptr     = 0;
  logic            hand_en   = 1'b0;
  logic [2*WD-1:0] hand_p [NREQ];

  logic [NREQ-1:0] exp_rdy;
  int              win;
  int              idx;
  logic            mon_exp_v;
  int              base;

  bmult_share_sched #(
    .NUM_REQ    (NREQ),
    .W          (WD),
    .LAT        (LATY),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mult_vld  (mult_vld),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  function automatic logic [2*WD-1:0] ref_prod(input logic [WD-1:0] a, input logic [WD-1:0] b);
    longint sa;
    longint sbv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    return (2*WD)'(sa * sbv);
  endfunction

  // Behavioural datapath: one register stage; junk when nothing was issued
  // and a random ignored top bit, so any unqualified sampling shows up.
  always @(posedge clk) begin
    if (mult_vld) mult_p <= {1'($urandom_range(0, 1)), ref_prod(mult_a, mult_b)};
    else          mult_p <= (2*WD+1)'($urandom);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference arbiter: predicts req_ready from its own pointer and the
  // scoreboard size (accepted and not yet popped) and queues the response.
  always begin
    @(negedge clk);
    if (rst) begin
      checkOutput("req_ready_in_reset", 64'(req_ready), 64'(0));
      scoreboard.delete();
      m_ptr = 0;
    end else begin
      exp_rdy = '0;
      win     = -1;
      if (scoreboard.size() < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && req_valid[IW'(idx)]) win = idx;
        end
      end
      if (win >= 0) exp_rdy[IW'(win)] = 1'b1;
      checkOutput("grant", 64'(req_ready), 64'(exp_rdy));
      if (|(req_valid & req_ready)) acc_count++;
      if (win >= 0) begin
        scoreboard.push_back('{id: win,
                               p: hand_en ? hand_p[IW'(win)] : ref_prod(req_a[IW'(win)], req_b[IW'(win)]),
                               avail: cycle + RSP_DELAY});
        m_ptr = (win + 1) % NREQ;
      end
    end
  end

  // Response monitor.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      mon_exp_v = 1'b0;
      if (scoreboard.size() > 0) begin
        if (scoreboard[0].avail <= cycle) mon_exp_v = 1'b1;
      end
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(mon_exp_v));
      if (rsp_valid && mon_exp_v) begin
        checkOutput("rsp_id", 64'(rsp_id), 64'(scoreboard[0].id));
        checkOutput("rsp_p", 64'(rsp_p), 64'(scoreboard[0].p));
        if (rsp_ready) void'(scoreboard.pop_front());
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [WD-1:0] a, input logic [WD-1:0] b,
                               input logic [2*WD-1:0] p);
    int   k   = 0;
    logic got = 1'b0;
    @(posedge clk); #1;
    hand_en          = 1'b1;
    hand_p[IW'(id)]  = p;
    req_a[IW'(id)]   = a;
    req_b[IW'(id)]   = b;
    req_valid        = '0;
    req_valid[IW'(id)] = 1'b1;
    while (!got && k < 20) begin
      @(negedge clk);
      if (req_ready[IW'(id)]) got = 1'b1;
      k++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    checkOutput("accepted", 64'(got), 64'(1));
  endtask

  task automatic setOperands(input int id, input logic [WD-1:0] a, input logic [WD-1:0] b,
                             input logic [2*WD-1:0] p);
    req_a[IW'(id)]  = a;
    req_b[IW'(id)]  = b;
    hand_p[IW'(id)] = p;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (scoreboard.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain_outstanding", 64'(scoreboard.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    for (int i = 0; i < NREQ; i++) hand_p[i] = '0;

    // Reset values with requests pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mult_vld", 64'(mult_vld), 64'(0));
    checkOutput("rst_mult_a", 64'(mult_a), 64'(0));
    checkOutput("rst_mult_b", 64'(mult_b), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'(0));
    checkOutput("rst_rsp_p", 64'(rsp_p), 64'(0));
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;

    // Single request and operand extremes.
    $display("[TB] directed single requests");
    applyStimulus(2, 10'h1FF, 10'h3FF, 20'hFFE01);
    drain(20);
    applyStimulus(0, 10'h200, 10'h200, 20'h40000);
    applyStimulus(1, 10'h000, 10'h1FF, 20'h00000);
    applyStimulus(3, 10'h1FF, 10'h1FF, 20'h3FC01);
    applyStimulus(2, 10'h200, 10'h1FF, 20'hC0200);
    applyStimulus(0, 10'h3FF, 10'h3FF, 20'h00001);
    drain(20);

    // All requesters valid, consumer always ready: one grant per cycle.
    $display("[TB] round robin at full rate");
    @(posedge clk); #1;
    setOperands(0, 10'h003, 10'h3FE, 20'hFFFFA);
    setOperands(1, 10'h3F9, 10'h005, 20'hFFFDD);
    setOperands(2, 10'h064, 10'h064, 20'h02710);
    setOperands(3, 10'h2D4, 10'h2D4, 20'h15F90);
    req_valid = '1;
    base      = acc_count;
    repeat (12) @(posedge clk); #1;
    req_valid = '0;
    checkOutput("rr_throughput", 64'(acc_count - base), 64'(12));
    drain(30);

    // Consumer stalled: exactly DEPTH accepts, then one pop frees one slot.
    $display("[TB] back-pressure");
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '1;
    base      = acc_count;
    repeat (8) @(posedge clk); #1;
    checkOutput("stall_accepts", 64'(acc_count - base), 64'(DEPTH));
    rsp_ready = 1'b1;
    base      = acc_count;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    repeat (4) @(posedge clk); #1;
    checkOutput("one_pop_one_grant", 64'(acc_count - base), 64'(1));
    req_valid = '0;
    rsp_ready = 1'b1;
    drain(30);

    // Reset with three operations in flight.
    $display("[TB] reset mid-operation");
    @(posedge clk); #1;
    req_valid = 4'b1110;
    repeat (3) @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rr_restart", 64'(req_ready), 64'(4'b0001));
    checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    req_valid = '0;
    drain(30);

    // Random traffic against the reference model.
    $display("[TB] random traffic");
    hand_en = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      for (int j = 0; j < NREQ; j++) begin
        req_a[j] = WD'($urandom);
        req_b[j] = WD'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    drain(100);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
